ua_rx_fifo: RTL and testbench

- Receive-side byte buffer that sits directly downstream of the UART receiver.
- Watches the receiver's byte output and its active-low "busy during stop bit" ready flag, captures each completed byte, and stores it in a synchronous FIFO.
- Host logic drains the FIFO with a simple read-strobe handshake.
- Flags overrun when a byte arrives while the FIFO is full.

---
 rtl/ua_pkg.sv | 14 +
 rtl/ua_sync_fifo.sv | 90 +++++++++
 rtl/ua_rx_fifo.sv | 79 +++++++
 tb/tb_ua_rx_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ua_pkg.sv
// Shared UART receive-path constants.
//   UA_DATA_W      : receiver byte width
//   UA_FIFO_ADDR_W : receive FIFO address width (depth = 2**UA_FIFO_ADDR_W)
package ua_pkg;

    localparam int unsigned UA_DATA_W      = 8;
    localparam int unsigned UA_FIFO_ADDR_W = 4;

    // Entry count of a FIFO with the given address width.
    function automatic int unsigned ua_fifo_depth(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/ua_sync_fifo.sv
// Generic synchronous FIFO with registered read data and occupancy count.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en, wr_data      : write request and byte; accepted if not full or a read
//                         is accepted in the same clk
//   rd_en               : read strobe; ignored while empty
//   rd_data, rd_valid   : popped entry (held between pops), one-clk valid pulse
//   empty, full, level  : occupancy, derived from the registered count
module ua_sync_fifo
    import ua_pkg::*;
#(
    parameter int unsigned DATA_W = UA_DATA_W,
    parameter int unsigned ADDR_W = UA_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level
);

    localparam int unsigned DEPTH = ua_fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_rd;
    logic              do_wr;

    // A read in the same clk frees a slot, so a full FIFO still takes the write.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    assign empty = (level == '0);
    assign full  = (level == (ADDR_W+1)'(DEPTH));

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at ADDR_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({do_wr, do_rd})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Read port: data held between pops, valid pulses for one clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: rtl/ua_rx_fifo.sv
// Receive byte buffer behind the UART receiver: captures each completed byte
// one clk after the ready flag rises, queues it, and flags dropped bytes.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   rx_byte, rx_rdy   : receiver byte and ready flag (low during stop bit)
//   rd_en             : host read strobe
//   rd_data, rd_valid : popped byte and its one-clk valid pulse
//   empty, full, level: FIFO occupancy
//   overrun, ovr_clr  : sticky drop flag and its clear
module ua_rx_fifo
    import ua_pkg::*;
#(
    parameter int unsigned DATA_W = UA_DATA_W,
    parameter int unsigned ADDR_W = UA_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_byte,
    input  logic              rx_rdy,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overrun,
    input  logic              ovr_clr
);

    logic rdy_q;
    logic cap_pend;
    logic rise;
    logic drop;

    // rdy_q resets high so a flag already high out of reset is not a rise.
    assign rise = rx_rdy & ~rdy_q;

    // Full with no read to free a slot: the capture is lost.
    assign drop = cap_pend & full & ~rd_en;

    // Rise detector and one-clk delay matching the receiver's byte register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q    <= 1'b1;
            cap_pend <= 1'b0;
        end else begin
            rdy_q    <= rx_rdy;
            cap_pend <= rise;
        end
    end

    // Sticky overrun; a new drop wins over a clear in the same clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    ua_sync_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cap_pend),
        .wr_data  (rx_byte),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level)
    );

endmodule

// File: tb/tb_ua_rx_fifo.sv
// Self-checking bench for ua_rx_fifo: directed scenarios plus random traffic,
// compared every clk against a queue-based reference model.
module tb_ua_rx_fifo;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_rdy = 1'b1;
    logic       rd_en = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    byte unsigned m_q[$];
    bit           m_ovr;
    bit           m_pend;
    bit           m_prev_rdy;
    bit           m_rv;
    byte unsigned m_rd;

    ua_rx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .rx_byte  (rx_byte),
        .rx_rdy   (rx_rdy),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr      = 1'b0;
        m_pend     = 1'b0;
        m_prev_rdy = 1'b1;
        m_rv       = 1'b0;
        m_rd       = 8'h00;
    endtask

    // One clk of the specified behaviour, using the inputs applied this cycle.
    task automatic model_step();
        bit do_rd;
        bit do_wr;
        bit ovr_set;
        int sz;
        sz      = m_q.size();
        do_rd   = rd_en && (sz > 0);
        do_wr   = m_pend && ((sz < DEPTH) || do_rd);
        ovr_set = m_pend && (sz == DEPTH) && !rd_en;
        m_rv = do_rd;
        if (do_rd) m_rd = m_q.pop_front();
        if (do_wr) m_q.push_back(rx_byte);
        if (ovr_set) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
        m_pend     = rx_rdy && !m_prev_rdy;
        m_prev_rdy = rx_rdy;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"},    32'(level),    32'(m_q.size()));
        check({tag, ".empty"},    32'(empty),    32'(m_q.size() == 0));
        check({tag, ".full"},     32'(full),     32'(m_q.size() == DEPTH));
        check({tag, ".overrun"},  32'(overrun),  32'(m_ovr));
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
        check({tag, ".rd_data"},  32'(rd_data),  32'(m_rd));
    endtask

    // Apply inputs at the falling edge, clock once, check just after the edge.
    task automatic cyc(input string tag, input logic rdy, input logic [7:0] b,
                       input logic rd, input logic clr);
        rx_rdy  = rdy;
        rx_byte = b;
        rd_en   = rd;
        ovr_clr = clr;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    // Receiver emulation: stop-bit low, rise with stale byte, then new byte.
    task automatic send_byte(input string tag, input logic [7:0] b, input logic rd_at_wr);
        cyc(tag, 1'b0, 8'($urandom), 1'b0, 1'b0);
        cyc(tag, 1'b1, 8'($urandom), 1'b0, 1'b0);
        cyc(tag, 1'b1, b, rd_at_wr, 1'b0);
    endtask

    task automatic read_one(input string tag);
        cyc(tag, 1'b1, 8'($urandom), 1'b1, 1'b0);
        cyc(tag, 1'b1, 8'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: ready held high never writes
        for (int i = 0; i < 50; i++) cyc("idle", 1'b1, 8'($urandom), 1'b0, 1'b0);
        check("idle.level_zero", 32'(level), 32'd0);

        // 2: three bytes in, three out in order
        send_byte("t2", 8'h55, 1'b0);
        send_byte("t2", 8'hA3, 1'b0);
        send_byte("t2", 8'h0F, 1'b0);
        read_one("t2");
        check("t2.first", 32'(rd_data), 32'h55);
        read_one("t2");
        check("t2.second", 32'(rd_data), 32'hA3);
        read_one("t2");
        check("t2.third", 32'(rd_data), 32'h0F);
        check("t2.empty", 32'(empty), 32'd1);

        // 3: fill, overrun, drain, clear
        for (int i = 0; i < 16; i++) send_byte("t3", 8'(i), 1'b0);
        check("t3.full", 32'(full), 32'd1);
        send_byte("t3", 8'hFF, 1'b0);
        check("t3.overrun", 32'(overrun), 32'd1);
        check("t3.level16", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            read_one("t3");
            check("t3.drain", 32'(rd_data), 32'(i));
        end
        check("t3.empty", 32'(empty), 32'd1);
        cyc("t3.clr", 1'b1, 8'h00, 1'b0, 1'b1);
        check("t3.cleared", 32'(overrun), 32'd0);

        // 4: full plus simultaneous read accepts the write
        for (int i = 0; i < 16; i++) send_byte("t4", 8'($urandom), 1'b0);
        send_byte("t4", 8'h77, 1'b1);
        check("t4.no_ovr", 32'(overrun), 32'd0);
        check("t4.level16", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) read_one("t4");
        check("t4.last", 32'(rd_data), 32'h77);

        // 5: read on empty with write in the same clk is ignored
        send_byte("t5", 8'h42, 1'b1);
        check("t5.no_valid", 32'(rd_valid), 32'd0);
        cyc("t5.rd", 1'b1, 8'h00, 1'b1, 1'b0);
        check("t5.data", 32'(rd_data), 32'h42);
        check("t5.valid", 32'(rd_valid), 32'd1);
        cyc("t5", 1'b1, 8'h00, 1'b0, 1'b0);

        // 6: reset with level 5 and a capture pending
        for (int i = 0; i < 5; i++) send_byte("t6", 8'($urandom), 1'b0);
        cyc("t6", 1'b0, 8'h00, 1'b0, 1'b0);
        cyc("t6", 1'b1, 8'hEE, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check("t6.level", 32'(level), 32'd0);
        check("t6.empty", 32'(empty), 32'd1);
        check("t6.rd_valid", 32'(rd_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc("t6.after", 1'b1, 8'hEE, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc("rand", ($urandom_range(0, 3) != 0), 8'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
